// File: rtl/bk_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : bk_pkg                                                       |
// | Description : Shared definitions for the Brent-Kung adder: maximum legal   |
// |               operand width, prefix-tree depth helper and the (g,p) pair   |
// |               type.                                                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package bk_pkg;

  // Widest operand the adder is qualified for.
  localparam int MAX_BITS = 128;

  // Generate/propagate pair carried through the prefix network.
  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // Depth of the up-sweep tree for a power-of-two operand width.
  function automatic int LEVELS(input int width);
    return $clog2(width);
  endfunction

endpackage : bk_pkg
`default_nettype wire

// File: rtl/bk_gp_cell.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bk_gp_cell                                                   |
// | Description : Prefix "black" cell. Merges a higher-order (G,P) group with  |
// |               the adjacent lower-order group:                              |
// |                 G = g_hi | (p_hi & g_lo),  P = p_hi & p_lo                 |
// | Ports       : g_hi, p_hi  in  1  generate/propagate of the upper group     |
// |               g_lo, p_lo  in  1  generate/propagate of the lower group     |
// |               g_out       out 1  merged group generate                     |
// |               p_out       out 1  merged group propagate                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module bk_gp_cell
  import bk_pkg::*;
(
  input  logic g_hi,
  input  logic p_hi,
  input  logic g_lo,
  input  logic p_lo,
  output logic g_out,
  output logic p_out
);

  assign g_out = g_hi | (p_hi & g_lo);
  assign p_out = p_hi & p_lo;

endmodule : bk_gp_cell
`default_nettype wire

// File: rtl/brent_kung_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : brent_kung_adder                                             |
// | Description : Registered carry-lookahead adder, {Cout,SUM} = A + B + Cin,  |
// |               with a Brent-Kung parallel-prefix carry network. One cycle   |
// |               of latency, a new operand set accepted every clock.          |
// | Parameters  : bits  operand width, power of two in [2, MAX_BITS]           |
// | Ports       : clk   in   1     rising-edge clock                           |
// |               rst   in   1     asynchronous active-high reset              |
// |               A     in   bits  addend A                                    |
// |               B     in   bits  addend B                                    |
// |               Cin   in   1     carry in                                    |
// |               SUM   out  bits  registered sum                              |
// |               Cout  out  1     registered carry out                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module brent_kung_adder
  import bk_pkg::*;
#(
  parameter int bits = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [bits-1:0] A,
  input  logic [bits-1:0] B,
  input  logic            Cin,
  output logic [bits-1:0] SUM,
  output logic            Cout
);

  localparam int L      = LEVELS(bits);
  // Stage 0 holds the bit-level (g,p); stages 1..L are the up-sweep,
  // stages L+1..2L-1 the down-sweep.
  localparam int NSTAGE = 2 * L;
  localparam int LAST   = NSTAGE - 1;

  if ((bits < 2) || (bits > MAX_BITS) || ((bits & (bits - 1)) != 0)) begin : g_bad_bits
    $error("brent_kung_adder: bits=%0d must be a power of two in [2,%0d]", bits, MAX_BITS);
  end

  // --------------------------------------------------------------------------
  // Bit-level pre-processing. Cin is absorbed into the bit-0 generate so the
  // prefix network never needs a separate carry input.
  // --------------------------------------------------------------------------
  logic [bits-1:0] w_g0;
  logic [bits-1:0] w_p0;

  assign w_p0 = A ^ B;
  assign w_g0 = (A & B) | {{(bits-1){1'b0}}, w_p0[0] & Cin};

  // --------------------------------------------------------------------------
  // Prefix network. Every stage carries a full (G,P) vector; positions that
  // do not combine at a given level simply pass their value through.
  // --------------------------------------------------------------------------
  for (genvar s = 0; s < NSTAGE; s++) begin : g_net
    logic [bits-1:0] w_g;
    logic [bits-1:0] w_p;

    if (s == 0) begin : g_pre
      assign w_g = w_g0;
      assign w_p = w_p0;
    end else begin : g_lvl
      localparam bit UP   = (s <= L);
      localparam int LV   = UP ? s : (2 * L - s);
      localparam int SPAN = 1 << LV;
      localparam int D    = 1 << (LV - 1);

      for (genvar i = 0; i < bits; i++) begin : g_bit
        // Up-sweep builds power-of-two aligned groups; down-sweep fills in the
        // intermediate prefixes from groups already complete down to bit 0.
        localparam bit ACTIVE = UP ? (((i + 1) % SPAN) == 0)
                                   : ((((i + 1) % SPAN) == D) && (i >= SPAN));
        if (ACTIVE) begin : g_cell
          bk_gp_cell u_cell (
            .g_hi  (g_net[s-1].w_g[i]),
            .p_hi  (g_net[s-1].w_p[i]),
            .g_lo  (g_net[s-1].w_g[i-D]),
            .p_lo  (g_net[s-1].w_p[i-D]),
            .g_out (w_g[i]),
            .p_out (w_p[i])
          );
        end else begin : g_pass
          assign w_g[i] = g_net[s-1].w_g[i];
          assign w_p[i] = g_net[s-1].w_p[i];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Sum formation. After both sweeps position i holds G[0:i] = carry into i+1.
  // The final group propagate has no consumer; fold it into a sink.
  // --------------------------------------------------------------------------
  logic [bits-1:0] w_carry;
  logic [bits-1:0] w_sum;
  logic            w_cout;
  logic            w_unused_p;

  assign w_carry    = {g_net[LAST].w_g[bits-2:0], Cin};
  assign w_sum      = w_p0 ^ w_carry;
  assign w_cout     = g_net[LAST].w_g[bits-1];
  assign w_unused_p = ^g_net[LAST].w_p;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      SUM  <= '0;
      Cout <= 1'b0;
    end else begin
      SUM  <= w_sum;
      Cout <= w_cout;
    end
  end

endmodule : brent_kung_adder
`default_nettype wire

// File: tb/tb_brent_kung_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_brent_kung_adder                                          |
// | Description : Scoreboard bench for brent_kung_adder at bits=64, 8 and 2.   |
// |               All three instances see the same (truncated) operands; the   |
// |               expected {Cout,SUM} is plain wide addition queued at drive   |
// |               time and popped by an independent monitor after each edge.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_brent_kung_adder;

  logic        clk;
  logic        rst;
  logic        cin;
  logic [63:0] a64, b64;
  logic [7:0]  a8, b8;
  logic [1:0]  a2, b2;
  logic [63:0] sum64;
  logic [7:0]  sum8;
  logic [1:0]  sum2;
  logic        cout64, cout8, cout2;
  logic        v_in;

  int n_checks = 0;
  int n_fail   = 0;

  logic [64:0] q64[$];
  logic [8:0]  q8[$];
  logic [2:0]  q2[$];

  brent_kung_adder #(.bits(64)) u_dut64 (
    .clk(clk), .rst(rst), .A(a64), .B(b64), .Cin(cin), .SUM(sum64), .Cout(cout64)
  );
  brent_kung_adder #(.bits(8)) u_dut8 (
    .clk(clk), .rst(rst), .A(a8), .B(b8), .Cin(cin), .SUM(sum8), .Cout(cout8)
  );
  brent_kung_adder #(.bits(2)) u_dut2 (
    .clk(clk), .rst(rst), .A(a2), .B(b2), .Cin(cin), .SUM(sum2), .Cout(cout2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Issue one operand set to all instances and queue the reference results.
  task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic c);
    @(negedge clk);
    a64 = a;       b64 = b;
    a8  = a[7:0];  b8  = b[7:0];
    a2  = a[1:0];  b2  = b[1:0];
    cin = c;
    v_in = 1'b1;
    q64.push_back({1'b0, a}       + {1'b0, b}       + {64'd0, c});
    q8.push_back ({1'b0, a[7:0]}  + {1'b0, b[7:0]}  + {8'd0, c});
    q2.push_back ({1'b0, a[1:0]}  + {1'b0, b[1:0]}  + {2'd0, c});
  endtask

  task automatic drive_random(input int n);
    for (int k = 0; k < n; k++)
      drive({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_w64"}, {cout64, sum64}, 65'd0);
    check({tag, "_w8"},  {56'd0, cout8, sum8}, 65'd0);
    check({tag, "_w2"},  {62'd0, cout2, sum2}, 65'd0);
  endtask

  // Monitor: whatever was presented at an edge is compared just after it.
  initial begin
    logic cap;
    logic [64:0] e64, e8, e2;
    forever begin
      @(posedge clk);
      cap = v_in && !rst;
      #1;
      if (cap) begin
        if (q64.size() == 0 || q8.size() == 0 || q2.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL scoreboard_underflow: got=empty expected=entry at t=%0t", $time);
        end else begin
          e64 = q64.pop_front();
          e8  = {56'd0, q8.pop_front()};
          e2  = {62'd0, q2.pop_front()};
          check("sum_w64", {cout64, sum64}, e64);
          check("sum_w8",  {56'd0, cout8, sum8}, e8);
          check("sum_w2",  {62'd0, cout2, sum2}, e2);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    v_in = 1'b0;
    a64 = '0; b64 = '0; a8 = '0; b8 = '0; a2 = '0; b2 = '0; cin = 1'b0;
    rst = 1'b1;
    #1;
    check_all_zero("reset_async");
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_held");
    @(negedge clk);
    rst = 1'b0;

    // Directed boundary cases.
    drive(64'd0, 64'd0, 1'b0);
    drive(64'd0, 64'd0, 1'b1);
    drive('1, '1, 1'b1);
    drive('1, '1, 1'b0);
    drive('1, 64'd0, 1'b1);
    drive(64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1);
    drive(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
    drive(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0);

    // Back-to-back random traffic.
    drive_random(120);

    // Mid-stream asynchronous reset with all-ones operands registered.
    @(negedge clk);
    v_in = 1'b0;
    a64 = '1; b64 = '1; a8 = '1; b8 = '1; a2 = '1; b2 = '1; cin = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("reset_midstream");
    @(posedge clk);
    #1;
    check_all_zero("reset_hold_edge");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all_zero("reset_release_noedge");

    drive_random(30);
    drive('1, '1, 1'b1);

    @(negedge clk);
    v_in = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("queue_drain", 65'(q64.size() + q8.size() + q2.size()), 65'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_brent_kung_adder
`default_nettype wire
